// File: rtl/multiport_regfile_if.sv
// Register file bus: packed write ports, issue (scoreboard set) port, packed read ports.
interface multiport_regfile_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 32,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 1
);
   localparam int AW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

   logic [NUM_WR-1:0]            wr_en;
   logic [NUM_WR*AW-1:0]         wr_addr;
   logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
   logic [NUM_RD*AW-1:0]         rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
   logic                         issue_en;
   logic [AW-1:0]                issue_addr;
   logic [NUM_RD-1:0]            rd_busy;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_addr,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/multiport_regfile.sv
// Multiport register file with per-register pending (scoreboard) bits,
// optional write-to-read forwarding and optional hardwired-zero register 0.

// One read port: storage/pending mux plus same-cycle forwarding from the write ports.
module multiport_regfile_rdport #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 32,
   parameter int NUM_WR        = 1,
   parameter int BYPASS        = 1,
   parameter int ZERO_REG      = 1,
   parameter int AW            = 5
) (
   input  logic                                    i_rst,
   input  logic [AW-1:0]                           i_addr,
   input  logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] i_mem,
   input  logic [NUM_REGISTERS-1:0]                i_pending,
   input  logic [NUM_WR-1:0]                       i_wr_ok,
   input  logic [NUM_WR-1:0][AW-1:0]               i_wr_addr,
   input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]       i_wr_data,
   output logic [DATA_WIDTH-1:0]                   o_data,
   output logic                                    o_busy
);
   logic w_addr_ok;

   // Out-of-range addresses and (optionally) register 0 always read as zero, never busy
   assign w_addr_ok = (int'(i_addr) < NUM_REGISTERS) && !((ZERO_REG != 0) && (i_addr == '0));

   // Storage lookup, then forwarding overrides; ascending loop makes the highest port win
   always_comb begin
      o_data = '0;
      o_busy = 1'b0;
      if (!i_rst && w_addr_ok) begin
         for (int i = 0; i < NUM_REGISTERS; i++) begin
            if (i_addr == AW'(i)) begin
               o_data = i_mem[i];
               o_busy = i_pending[i];
            end
         end
         if (BYPASS != 0) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (i_wr_ok[p] && (i_wr_addr[p] == i_addr)) begin
                  o_data = i_wr_data[p];
                  o_busy = 1'b0;
               end
            end
         end
      end
   end
endmodule

module multiport_regfile #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 32,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 1,
   parameter int BYPASS        = 1,
   parameter int ZERO_REG      = 1
) (
   input logic               clk,
   input logic               rst,
   multiport_regfile_if.slave bus
);
   localparam int AW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

   logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] r_mem;
   logic [NUM_REGISTERS-1:0]                 r_pending;

   logic [NUM_WR-1:0][AW-1:0]         w_wr_addr;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0] w_wr_data;
   logic [NUM_WR-1:0]                 w_wr_ok;
   logic                              w_iss_ok;
   logic [NUM_RD-1:0][AW-1:0]         w_rd_addr;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] w_rd_data;
   logic [NUM_RD-1:0]                 w_rd_busy;

   // A write or issue only counts if it targets a real, writable register
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (int'(a) < NUM_REGISTERS) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   genvar gp, gr;
   generate
      for (gp = 0; gp < NUM_WR; gp++) begin : g_wr
         assign w_wr_addr[gp] = bus.wr_addr[gp*AW +: AW];
         assign w_wr_data[gp] = bus.wr_data[gp*DATA_WIDTH +: DATA_WIDTH];
         assign w_wr_ok[gp]   = bus.wr_en[gp] && addr_ok(w_wr_addr[gp]);
      end
   endgenerate

   assign w_iss_ok = bus.issue_en && addr_ok(bus.issue_addr);

   // Commit writes (highest port last so it wins), clear pending on commit,
   // then set pending on issue so a same-cycle new producer stays visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem     <= '0;
         r_pending <= '0;
      end else begin
         for (int i = 0; i < NUM_REGISTERS; i++) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (w_wr_ok[p] && (w_wr_addr[p] == AW'(i))) begin
                  r_mem[i]     <= w_wr_data[p];
                  r_pending[i] <= 1'b0;
               end
            end
            if (w_iss_ok && (bus.issue_addr == AW'(i))) r_pending[i] <= 1'b1;
         end
      end
   end

   generate
      for (gr = 0; gr < NUM_RD; gr++) begin : g_rd
         assign w_rd_addr[gr] = bus.rd_addr[gr*AW +: AW];
         multiport_regfile_rdport #(
            .DATA_WIDTH   (DATA_WIDTH),
            .NUM_REGISTERS(NUM_REGISTERS),
            .NUM_WR       (NUM_WR),
            .BYPASS       (BYPASS),
            .ZERO_REG     (ZERO_REG),
            .AW           (AW)
         ) u_rd (
            .i_rst    (rst),
            .i_addr   (w_rd_addr[gr]),
            .i_mem    (r_mem),
            .i_pending(r_pending),
            .i_wr_ok  (w_wr_ok),
            .i_wr_addr(w_wr_addr),
            .i_wr_data(w_wr_data),
            .o_data   (w_rd_data[gr]),
            .o_busy   (w_rd_busy[gr])
         );
      end
   endgenerate

   assign bus.rd_data = w_rd_data;
   assign bus.rd_busy = w_rd_busy;
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: instance A (bypass, zero reg, 32 regs) and instance B
// (no bypass, no zero reg, 24 regs) driven with the same stimulus.
module tb_multiport_regfile;
   logic clk;
   logic rst;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   multiport_regfile_if #(.DATA_WIDTH(32), .NUM_REGISTERS(32), .NUM_RD(2), .NUM_WR(2)) a_if ();
   multiport_regfile_if #(.DATA_WIDTH(32), .NUM_REGISTERS(24), .NUM_RD(2), .NUM_WR(2)) b_if ();

   multiport_regfile #(.DATA_WIDTH(32), .NUM_REGISTERS(32), .NUM_RD(2), .NUM_WR(2),
                       .BYPASS(1), .ZERO_REG(1)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   multiport_regfile #(.DATA_WIDTH(32), .NUM_REGISTERS(24), .NUM_RD(2), .NUM_WR(2),
                       .BYPASS(0), .ZERO_REG(0)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] da(input int r);
      return a_if.rd_data[r*32 +: 32];
   endfunction
   function automatic logic [31:0] db(input int r);
      return b_if.rd_data[r*32 +: 32];
   endfunction
   function automatic logic [31:0] ba(input int r);
      return {31'd0, a_if.rd_busy[r]};
   endfunction
   function automatic logic [31:0] bb(input int r);
      return {31'd0, b_if.rd_busy[r]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Write enables low, but junk on the data/address lines to catch unguarded writes
   task automatic idle;
      a_if.wr_en = '0;             b_if.wr_en = '0;
      a_if.wr_addr[0 +: 5] = 5'd1; b_if.wr_addr[0 +: 5] = 5'd1;
      a_if.wr_addr[5 +: 5] = 5'd2; b_if.wr_addr[5 +: 5] = 5'd2;
      a_if.wr_data = {2{32'hBAD0BAD0}};
      b_if.wr_data = {2{32'hBAD0BAD0}};
      a_if.issue_en = 1'b0;        b_if.issue_en = 1'b0;
      a_if.issue_addr = '0;        b_if.issue_addr = '0;
   endtask

   task automatic wr(input int p, input int addr, input logic [31:0] d);
      a_if.wr_en[p] = 1'b1;             b_if.wr_en[p] = 1'b1;
      a_if.wr_addr[p*5 +: 5] = 5'(addr); b_if.wr_addr[p*5 +: 5] = 5'(addr);
      a_if.wr_data[p*32 +: 32] = d;      b_if.wr_data[p*32 +: 32] = d;
   endtask

   task automatic rd(input int r, input int addr);
      a_if.rd_addr[r*5 +: 5] = 5'(addr);
      b_if.rd_addr[r*5 +: 5] = 5'(addr);
   endtask

   task automatic iss(input int addr);
      a_if.issue_en = 1'b1;       b_if.issue_en = 1'b1;
      a_if.issue_addr = 5'(addr); b_if.issue_addr = 5'(addr);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      rd(0, 1); rd(1, 2);
      #1;
      chk("rst_a_rd0", da(0), 32'h0);
      chk("rst_a_busy0", ba(0), 32'h0);
      chk("rst_b_rd1", db(1), 32'h0);
      #10 rst = 1'b0;

      // r1/r2 writes, read back next cycle
      wr(0, 1, 32'hDEADBEEF); wr(1, 2, 32'h12345678);
      #1;
      chk("byp_a_r1", da(0), 32'hDEADBEEF);
      chk("nobyp_b_r1", db(0), 32'h0);
      tick(); idle(); #1;
      chk("a_r1", da(0), 32'hDEADBEEF);
      chk("a_r2", da(1), 32'h12345678);
      chk("b_r1", db(0), 32'hDEADBEEF);
      chk("b_r2", db(1), 32'h12345678);

      // register 0
      wr(0, 0, 32'hA5A5A5A5); rd(0, 0);
      #1;
      chk("a_r0_byp", da(0), 32'h0);
      chk("b_r0_pre", db(0), 32'h0);
      tick(); idle(); #1;
      chk("a_r0", da(0), 32'h0);
      chk("b_r0", db(0), 32'hA5A5A5A5);

      // forwarding on r5
      wr(0, 5, 32'hCAFEF00D); rd(0, 5);
      #1;
      chk("a_r5_byp", da(0), 32'hCAFEF00D);
      chk("b_r5_old", db(0), 32'h0);
      tick(); idle(); #1;
      chk("a_r5", da(0), 32'hCAFEF00D);
      chk("b_r5_new", db(0), 32'hCAFEF00D);

      // two ports to r7: port 1 wins
      wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7);
      #1;
      chk("a_r7_byp", da(0), 32'h2222);
      tick(); idle(); #1;
      chk("a_r7", da(0), 32'h2222);
      chk("b_r7", db(0), 32'h2222);

      // scoreboard on r3
      iss(3); rd(1, 3);
      #1;
      chk("a_busy3_pre", ba(1), 32'h0);
      tick(); idle(); #1;
      chk("a_busy3", ba(1), 32'h1);
      chk("b_busy3", bb(1), 32'h1);
      wr(0, 3, 32'h33);
      #1;
      chk("a_busy3_byp", ba(1), 32'h0);
      chk("b_busy3_wr", bb(1), 32'h1);
      tick(); idle(); #1;
      chk("a_busy3_clr", ba(1), 32'h0);
      chk("b_busy3_clr", bb(1), 32'h0);
      chk("b_r3", db(1), 32'h33);
      iss(3); wr(0, 3, 32'h44);
      tick(); idle(); #1;
      chk("a_busy3_isswr", ba(1), 32'h1);
      chk("b_busy3_isswr", bb(1), 32'h1);
      chk("a_r3_isswr", da(1), 32'h44);
      chk("b_r3_isswr", db(1), 32'h44);
      iss(3);
      tick(); idle(); #1;
      chk("a_busy3_reiss", ba(1), 32'h1);

      // r30 is out of range for the 24-entry instance
      wr(0, 30, 32'h5555); rd(0, 30);
      tick(); idle(); #1;
      chk("a_r30", da(0), 32'h5555);
      chk("b_r30_oor", db(0), 32'h0);

      // register 0 never pending when hardwired
      iss(0); rd(0, 0);
      tick(); idle(); #1;
      chk("a_busy0", ba(0), 32'h0);
      chk("b_busy0", bb(0), 32'h1);
      chk("b_r0_keep", db(0), 32'hA5A5A5A5);

      // async reset between edges with r1 pending
      iss(1); rd(0, 1); rd(1, 2);
      tick(); idle(); #1;
      chk("a_r1_pend", ba(0), 32'h1);
      chk("a_r1_val", da(0), 32'hDEADBEEF);
      #2 rst = 1'b1;
      #1;
      chk("arst_a_rd0", da(0), 32'h0);
      chk("arst_a_busy0", ba(0), 32'h0);
      chk("arst_b_rd0", db(0), 32'h0);
      chk("arst_b_busy0", bb(0), 32'h0);
      chk("arst_a_rd1", da(1), 32'h0);
      wr(0, 1, 32'h77); iss(1);
      #1;
      chk("arst_a_nobyp", da(0), 32'h0);
      tick(); #1;
      chk("arst_a_wr_ign", da(0), 32'h0);
      chk("arst_a_iss_ign", ba(0), 32'h0);
      rst = 1'b0;
      idle();
      tick(); #1;
      chk("post_a_r1", da(0), 32'h0);
      chk("post_b_r1", db(0), 32'h0);
      chk("post_b_busy1", bb(0), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
